result_stream_out: RTL

Downstream drain stage of the matrix-multiply datapath. When the PL controller pulses `data_ready` at the end of a result round, this block reads `MATSIZE` result words from the output buffer BRAM. The BRAM has one-cycle read latency. The block buffers the words in a small FIFO and emits them as an AXI4-Stream master packet, with `tlast` on the final word. It absorbs arbitrary `tready` backpressure without losing or duplicating words.

---
 rtl/mat_pkg.sv | 21 ++
 rtl/result_fifo.sv | 65 ++++++
 rtl/result_stream_out.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiply datapath: default dimensions and the
// drain-stage state encoding.
package mat_pkg;

    localparam int unsigned MATSIZE_DEF    = 16;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned ADDR_W_DEF     = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rso_state_t;

    // Width of a counter that must be able to hold the value n without wrapping.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; data_o always shows the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/result_stream_out.sv
// Drains MATSIZE result words from the output BRAM into an AXI4-Stream packet.
// Optional feature: define RESULT_STREAM_CNT_EN to add the pkt_count_o completed-packet counter.
module result_stream_out
    import mat_pkg::*;
#(
    parameter int unsigned MATSIZE    = MATSIZE_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_ready_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
`ifdef RESULT_STREAM_CNT_EN
    ,
    output logic [15:0]       pkt_count_o
`endif
);

    localparam int unsigned     CntW     = cnt_w(MATSIZE);
    localparam int unsigned     FcW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] LastIdx  = CntW'(MATSIZE - 1);
    localparam logic [FcW:0]    DepthLim = (FcW + 1)'(FIFO_DEPTH);

    rso_state_t      state_q, state_d;
    logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0] emit_cnt_q, emit_cnt_d;
    logic            inflight_q;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;

    logic              fifo_full, fifo_empty;
    logic [FcW-1:0]    fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic start, room, issue, tvalid, hs, last_hs, busy;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .data_i  (rd_data_i),
        .pop_i   (hs),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy    = (state_q != IDLE);
    assign tvalid  = ~fifo_empty;
    assign hs      = tvalid & m_axis_tready_i;
    assign last_hs = hs && (emit_cnt_q == LastIdx);
    // A start landing on the done cycle is refused so done never overlaps a new packet.
    assign start   = data_ready_i && (state_q == IDLE) && !done_q;
    // The in-flight read already owns a FIFO slot, so it counts against the space.
    assign room    = (({1'b0, fifo_count} + {{FcW{1'b0}}, inflight_q}) < DepthLim) && !fifo_full;
    assign issue   = (state_q == READ) && room;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (issue && (issue_cnt_q == LastIdx)) state_d = DRAIN;
            DRAIN:   if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        emit_cnt_d  = emit_cnt_q;
        if (start) begin
            issue_cnt_d = '0;
            emit_cnt_d  = '0;
        end else begin
            if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
            if (hs)    emit_cnt_d  = emit_cnt_q + 1'b1;
        end
        done_d    = last_hs;
        overrun_d = overrun_q | (data_ready_i & (busy | done_q));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            issue_cnt_q <= '0;
            emit_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            inflight_q  <= issue;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rd_en_o         = issue;
        rd_addr_o       = ADDR_W'(issue_cnt_q);
        m_axis_tvalid_o = tvalid;
        m_axis_tdata_o  = tvalid ? fifo_head : '0;
        m_axis_tlast_o  = tvalid && (emit_cnt_q == LastIdx);
        busy_o          = busy;
        done_o          = done_q;
        overrun_o       = overrun_q;
    end

`ifdef RESULT_STREAM_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
        end else if (done_q) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_count_o = pkt_cnt_q;
`else
    // Packet counter not built.
`endif

endmodule
